// File: rtl/calc_pkg.sv
// calc_pkg: opcode, flag index and sequencer state definitions for the calculator front end.
package calc_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NXOR = 4'h9,
        OP_NAND = 4'hA,
        OP_NOR  = 4'hB
    } op_t;
    localparam int FLG_Z  = 0;
    localparam int FLG_C  = 1;
    localparam int FLG_OV = 2;
    localparam int FLG_BR = 3;
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESP} ctrl_state_t;
endpackage

// File: rtl/calc_ctrl.sv
// calc_ctrl: collects opcode/A/B command bytes, drives the ALU and returns its result.
// Optional CALC_CTRL_OPCHECK_EN rejects unknown opcodes with an op_err pulse.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_dout,
    input  logic [3:0] alu_flags,
    output logic [7:0] res_data,
    output logic [3:0] res_flags,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       op_err,
    output logic       busy
);
    ctrl_state_t state, state_n;
    op_t         sel_q;
    logic [15:0] idle_cnt;
    logic        accept, gathering, timeout_hit, bad_op;
    assign accept      = in_valid && in_ready;
    assign gathering   = (state == GET_A) || (state == GET_B);
    assign timeout_hit = (TIMEOUT != 0) && gathering && !accept && (idle_cnt == 16'(TIMEOUT - 1));
    assign alu_sel     = sel_q;
    assign busy        = state != IDLE;
`ifdef CALC_CTRL_OPCHECK_EN
    logic bad_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) bad_q <= 1'b0;
        else if (accept && state == IDLE) bad_q <= (in_data[7:4] != 4'h0) || (in_data[3:0] >= 4'hC);
    assign bad_op = bad_q;
    assign op_err = (state == EXEC) && bad_q;
`else
    assign bad_op = 1'b0;
    assign op_err = 1'b0;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? GET_A : IDLE;
            GET_A:   state_n = accept ? GET_B : (timeout_hit ? IDLE : GET_A);
            GET_B:   state_n = accept ? EXEC : (timeout_hit ? IDLE : GET_B);
            EXEC:    state_n = bad_op ? IDLE : RESP;
            RESP:    state_n = res_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            sel_q     <= OP_ADD;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            res_data  <= 8'h00;
            res_flags <= 4'h0;
            res_valid <= 1'b0;
            idle_cnt  <= 16'h0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == IDLE) || (state_n == GET_A) || (state_n == GET_B);
            idle_cnt <= (accept || timeout_hit || !gathering) ? 16'h0 : idle_cnt + 16'h1;
            if (accept && state == IDLE) sel_q <= op_t'(in_data[3:0]);
            if (accept && state == GET_A) alu_a <= in_data;
            if (accept && state == GET_B) alu_b <= in_data;
            // Result registers change only in EXEC, so they hold steady through RESP.
            if (state == EXEC && !bad_op) begin
                res_data  <= alu_dout;
                res_flags <= alu_flags;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: table-driven frames plus directed backpressure, reset, timeout and opcode sequences.
module tb_calc_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] alu_a, alu_b, alu_dout, res_data;
    logic [3:0] alu_sel, alu_flags, res_flags;
    logic       res_valid, op_err, busy;
    logic       res_ready = 1'b1;
    int         passed = 0;
    int         total = 0;

    calc_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_dout(alu_dout), .alu_flags(alu_flags),
        .res_data(res_data), .res_flags(res_flags), .res_valid(res_valid), .res_ready(res_ready),
        .op_err(op_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU covering the opcodes used below; unknown opcodes yield zero result and flags.
    logic [8:0]  s9, d9;
    logic [15:0] p16;
    assign s9  = {1'b0, alu_a} + {1'b0, alu_b};
    assign d9  = {1'b0, alu_a} - {1'b0, alu_b};
    assign p16 = alu_a * alu_b;
    always_comb begin
        alu_dout  = 8'h00;
        alu_flags = 4'h0;
        case (alu_sel)
            4'h0: begin alu_dout = s9[7:0]; alu_flags = {1'b0, s9[8], 1'b0, s9[7:0] == 8'h00}; end
            4'h1: begin alu_dout = d9[7:0]; alu_flags = {alu_a < alu_b, 2'b00, d9[7:0] == 8'h00}; end
            4'h2: begin alu_dout = p16[7:0]; alu_flags = {1'b0, p16[15:8] != 8'h00, 2'b00}; end
            4'h6: begin alu_dout = alu_a & alu_b; alu_flags = {3'b000, (alu_a & alu_b) == 8'h00}; end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("in_ready_wait", 16'(in_ready), 16'h1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] ed, input logic [3:0] ef);
        send_byte(op);
        send_byte(a);
        send_byte(b);
        chk("alu_sel", 16'(alu_sel), 16'(op[3:0]));
        chk("alu_a", 16'(alu_a), 16'(a));
        chk("alu_b", 16'(alu_b), 16'(b));
        chk("exec_no_valid", 16'(res_valid), 16'h0);
        tick();
        chk("res_valid", 16'(res_valid), 16'h1);
        chk("res_data", 16'(res_data), 16'(ed));
        chk("res_flags", 16'(res_flags), 16'(ef));
        tick();
        chk("valid_drop", 16'(res_valid), 16'h0);
        chk("ready_back", 16'(in_ready), 16'h1);
    endtask

    typedef struct {
        logic [7:0] op, a, b, d;
        logic [3:0] f;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 8'h05, 8'h03, 8'h08, 4'h0};
        vecs[1] = '{8'h00, 8'hFF, 8'h01, 8'h00, 4'h5};
        vecs[2] = '{8'h01, 8'h03, 8'h05, 8'hFE, 4'h8};
        vecs[3] = '{8'h06, 8'hF0, 8'h0F, 8'h00, 4'h1};
        vecs[4] = '{8'h02, 8'h10, 8'h10, 8'h00, 4'h4};
        vecs[5] = '{8'h02, 8'h03, 8'h04, 8'h0C, 4'h0};
        tick();
        tick();
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_res_valid", 16'(res_valid), 16'h0);
        chk("rst_op_err", 16'(op_err), 16'h0);
        rst = 1'b0;
        chk("pre_edge_in_ready", 16'(in_ready), 16'h0);
        tick();
        chk("first_edge_in_ready", 16'(in_ready), 16'h1);

        foreach (vecs[i]) run_frame(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].f);

        // Backpressure: result must hold for 10 cycles with input blocked.
        res_ready = 1'b0;
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h03);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 16'(res_valid), 16'h1);
            chk("hold_data", 16'(res_data), 16'h08);
            chk("hold_flags", 16'(res_flags), 16'h0);
            chk("hold_in_ready", 16'(in_ready), 16'h0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("release_valid", 16'(res_valid), 16'h0);
        chk("release_in_ready", 16'(in_ready), 16'h1);
        chk("release_busy", 16'(busy), 16'h0);

        // Asynchronous reset mid-frame.
        send_byte(8'h06);
        send_byte(8'hF0);
        chk("mid_alu_a", 16'(alu_a), 16'hF0);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 16'(in_ready), 16'h0);
        chk("arst_busy", 16'(busy), 16'h0);
        chk("arst_alu_a", 16'(alu_a), 16'h00);
        chk("arst_alu_sel", 16'(alu_sel), 16'h0);
        chk("arst_res", 16'({res_data, res_flags, res_valid, op_err}), 16'h0);
        tick();
        rst = 1'b0;
        run_frame(8'h06, 8'hF0, 8'h0F, 8'h00, 4'h1);

        // Timeout after 4 idle cycles drops the partial frame.
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_busy", 16'(busy), 16'h1);
        end
        tick();
        chk("to_idle", 16'(busy), 16'h0);
        chk("to_no_valid", 16'(res_valid), 16'h0);
        chk("to_in_ready", 16'(in_ready), 16'h1);
        run_frame(8'h02, 8'h10, 8'h10, 8'h00, 4'h4);

        // A byte on the would-be timeout edge wins and restarts the count.
        send_byte(8'h00);
        repeat (3) tick();
        send_byte(8'h01);
        chk("edge_busy", 16'(busy), 16'h1);
        repeat (3) tick();
        send_byte(8'h02);
        chk("edge_alu_b", 16'(alu_b), 16'h02);
        tick();
        chk("edge_valid", 16'(res_valid), 16'h1);
        chk("edge_data", 16'(res_data), 16'h03);
        tick();

        // Out-of-range opcode.
        send_byte(8'h0C);
        send_byte(8'h01);
        send_byte(8'h02);
`ifdef CALC_CTRL_OPCHECK_EN
        chk("operr_pulse", 16'(op_err), 16'h1);
        tick();
        chk("operr_clear", 16'(op_err), 16'h0);
        chk("operr_no_valid", 16'(res_valid), 16'h0);
        chk("operr_idle", 16'(busy), 16'h0);
`else
        chk("operr_tied", 16'(op_err), 16'h0);
        tick();
        chk("op_c_valid", 16'(res_valid), 16'h1);
        chk("op_c_data", 16'({res_data, res_flags}), 16'h000);
        tick();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
